// File: rtl/sw_ctrl_pkg.sv
// rtl/sw_ctrl_pkg.sv - shared constants for the switch controller
package sw_ctrl_pkg;

    localparam int SW_WIDTH = 16;

    localparam logic [3:0] SW_DATA = 4'h0;
    localparam logic [3:0] SW_CHG  = 4'h4;
    localparam logic [3:0] SW_IE   = 4'h8;
    localparam logic [3:0] SW_STAT = 4'hC;

    // Registers are word aligned, so only the word index selects a register.
    function automatic logic [1:0] reg_index(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit sample history and stable-level acceptance
module sw_debounce #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic db,
    output logic change
);

    logic [STABLE_SAMPLES-2:0] hist;
    logic [STABLE_SAMPLES-1:0] window;

    // The window includes the sample being taken on this tick.
    assign window = {hist, din};

    always_comb begin
        change = 1'b0;
        if (tick) begin
            if ((&window) && !db) begin
                change = 1'b1;
            end
            if (!(|window) && db) begin
                change = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            db   <= 1'b0;
        end else if (tick) begin
            hist <= window[STABLE_SAMPLES-2:0];
            if (change) begin
                db <= ~db;
            end
        end
    end

endmodule

// File: rtl/sw_ctrl.sv
// rtl/sw_ctrl.sv - debounced slide-switch controller with change flags and irq
module sw_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int STABLE_SAMPLES  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic [3:0]          addr,
    input  logic                we,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync1, sync2;
    logic [CW-1:0]       cnt;
    logic                tick;
    logic [SW_WIDTH-1:0] db, change;
    logic [SW_WIDTH-1:0] chg, ie;
    logic                wr_chg, wr_ie;
    logic                unused_ok;

    assign unused_ok = ^{addr[1:0], wdata[31:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        sw_debounce #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .din   (sync2[i]),
            .db    (db[i]),
            .change(change[i])
        );
    end

    assign wr_chg = we && (addr[3:2] == reg_index(SW_CHG));
    assign wr_ie  = we && (addr[3:2] == reg_index(SW_IE));

    // A new change in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= '0;
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            chg <= (chg & ~(wr_chg ? wdata[SW_WIDTH-1:0] : '0)) | change;
            if (wr_ie) begin
                ie <= wdata[SW_WIDTH-1:0];
            end
            irq <= |(chg & ie);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            reg_index(SW_DATA): rdata = {16'd0, db};
            reg_index(SW_CHG):  rdata = {16'd0, chg};
            reg_index(SW_IE):   rdata = {16'd0, ie};
            reg_index(SW_STAT): rdata = {31'd0, irq};
            default:            rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_sw_ctrl.sv
// tb/tb_sw_ctrl.sv - directed self-checking bench for sw_ctrl
module tb_sw_ctrl;
    import sw_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc;

    sw_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STABLE_SAMPLES (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; every 4th one is a prescaler tick edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    logic [31:0] v;
    logic        found;

    initial begin
        rst_n = 1'b0;
        sw    = 16'h0000;
        addr  = 4'h0;
        we    = 1'b0;
        wdata = 32'd0;
        repeat (3) @(negedge clk);

        rd(SW_DATA, v); check("reset_data", v, 32'h0);
        rd(SW_CHG,  v); check("reset_chg",  v, 32'h0);
        rd(SW_IE,   v); check("reset_ie",   v, 32'h0);
        rd(SW_STAT, v); check("reset_stat", v, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rst_n = 1'b1;

        // Scenario 1: single switch accepted within 18 cycles
        repeat (5) @(negedge clk);
        sw = 16'h0001;
        found = 1'b0;
        for (int i = 0; i < 18 && !found; i++) begin
            @(negedge clk);
            rd(SW_DATA, v);
            if (v == 32'h1) found = 1'b1;
        end
        check("s1_latency", {31'd0, found}, 32'h1);
        rd(SW_DATA, v); check("s1_data", v, 32'h1);
        rd(SW_CHG,  v); check("s1_chg",  v, 32'h1);
        wr(SW_CHG, 32'h1);
        rd(SW_CHG,  v); check("s1_chg_clr", v, 32'h0);

        // Scenario 2: 5-cycle glitches on bit 3 never pass
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) sw[3] = ~sw[3];
            @(negedge clk);
            rd(SW_DATA, v); check("s2_data", v, 32'h1);
            rd(SW_CHG,  v); check("s2_chg",  v, 32'h0);
        end
        sw[3] = 1'b0;
        repeat (20) @(negedge clk);
        rd(SW_DATA, v); check("s2_data_end", v, 32'h1);
        rd(SW_CHG,  v); check("s2_chg_end",  v, 32'h0);

        // Scenario 3: irq follows chg & ie with one cycle of latency
        wr(SW_IE, 32'h1);
        sw = 16'h0000;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            rd(SW_CHG, v);
            if (v[0]) found = 1'b1;
        end
        check("s3_chg_seen", {31'd0, found}, 32'h1);
        check("s3_irq_lag", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check("s3_irq_set", {31'd0, irq}, 32'h1);
        rd(SW_STAT, v); check("s3_stat_set", v, 32'h1);
        rd(SW_DATA, v); check("s3_data", v, 32'h0);
        wr(SW_CHG, 32'h1);
        rd(SW_CHG, v); check("s3_chg_clr", v, 32'h0);
        check("s3_irq_hold", {31'd0, irq}, 32'h1);
        @(negedge clk);
        check("s3_irq_clr", {31'd0, irq}, 32'h0);
        rd(SW_STAT, v); check("s3_stat_clr", v, 32'h0);

        // Scenario 4: change on bit 5 coincides with a W1C of bit 5
        do @(negedge clk); while (cyc % 4 != 0);
        sw = 16'h0020;
        repeat (10) @(negedge clk);
        rd(SW_CHG, v); check("s4_chg_before", v, 32'h0);
        @(negedge clk);
        rd(SW_DATA, v); check("s4_data_before", v, 32'h0);
        wr(SW_CHG, 32'h20);
        rd(SW_DATA, v); check("s4_data", v, 32'h20);
        rd(SW_CHG,  v); check("s4_chg",  v, 32'h20);

        // Scenario 5: reset mid-debounce discards partial history
        wr(SW_CHG, 32'hFFFF);
        sw = 16'hFFFF;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        rd(SW_DATA, v); check("s5_rst_data", v, 32'h0);
        rd(SW_CHG,  v); check("s5_rst_chg",  v, 32'h0);
        rd(SW_IE,   v); check("s5_rst_ie",   v, 32'h0);
        check("s5_rst_irq", {31'd0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rd(SW_CHG, v); check("s5_no_spurious", v, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            rd(SW_DATA, v);
            if (v == 32'hFFFF) found = 1'b1;
        end
        check("s5_accept", {31'd0, found}, 32'h1);
        rd(SW_DATA, v); check("s5_data", v, 32'h0000FFFF);
        rd(SW_CHG,  v); check("s5_chg",  v, 32'h0000FFFF);

        // Scenario 6: read-only registers ignore writes, IE drops upper half
        wr(SW_DATA, 32'hFFFFFFFF);
        wr(SW_STAT, 32'hFFFFFFFF);
        wr(SW_IE,   32'hFFFFFFFF);
        rd(SW_IE,   v); check("s6_ie",   v, 32'h0000FFFF);
        rd(4'h9,    v); check("s6_ie_lowbits", v, 32'h0000FFFF);
        rd(SW_DATA, v); check("s6_data", v, 32'h0000FFFF);
        rd(SW_CHG,  v); check("s6_chg",  v, 32'h0000FFFF);
        @(negedge clk);
        rd(SW_STAT, v); check("s6_stat", v, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
